// File: rtl/egress_port_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : egress_port_queue                                           |
// | Purpose  : Per-port egress FIFO of {ctl, data} words with a registered |
// |            head and valid/ready output; drops writes instead of        |
// |            stalling. Optional macro EGRESS_PORT_CHECK_EN also drops    |
// |            words whose in_ctl[1:0] does not match PORT_ID.             |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module egress_port_queue #(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int PORT_ID    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_wr,
    input  logic [CTRL_WIDTH-1:0] in_ctl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  full,
    output logic                  drop_pulse
);

    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int RAM_DEPTH  = DEPTH - 1;
    localparam int WORD_WIDTH = CTRL_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FILL_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    generate
        if (PORT_ID < 0 || PORT_ID > 3) begin : g_port_id_invalid
            $error("egress_port_queue: PORT_ID must be in 0..3");
        end
    endgenerate

    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] out_word_q, out_word_d;
    logic [ADDR_WIDTH-1:0] ram_count_q, ram_count_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic                  drop_q, drop_d;

    logic [WORD_WIDTH-1:0] ram_q [RAM_DEPTH];
    logic                  ram_we;
    logic [WORD_WIDTH-1:0] ram_rdata;
    logic [WORD_WIDTH-1:0] in_word;
    logic                  full_w;
    logic                  port_ok;
    logic                  pop;
    logic                  accept;

    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef EGRESS_PORT_CHECK_EN
    localparam logic [1:0] PORT_ID_BITS = 2'(PORT_ID);
    assign port_ok = (in_ctl[1:0] == PORT_ID_BITS);
`else
    assign port_ok = 1'b1;
`endif

    assign in_word   = {in_ctl, in_data};
    assign ram_rdata = ram_q[rd_ptr_q];
    // Full is taken from the registered count, so a same-cycle pop never frees room.
    assign full_w    = (fill_q == FILL_MAX);
    assign pop       = out_valid_q & out_ready;
    assign accept    = in_wr & ~full_w & port_ok;

    always_comb begin
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        ram_count_d = ram_count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        ram_we      = 1'b0;
        drop_d      = in_wr & ~accept;

        case ({accept, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        // The RAM only ever holds words while the head register is occupied.
        if (!out_valid_q) begin
            if (accept) begin
                out_valid_d = 1'b1;
                out_word_d  = in_word;
            end
        end else if (pop) begin
            if (ram_count_q != '0) begin
                out_word_d = ram_rdata;
                rd_ptr_d   = ptr_next(rd_ptr_q);
                if (accept) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = ptr_next(wr_ptr_q);
                end else begin
                    ram_count_d = ram_count_q - 1'b1;
                end
            end else if (accept) begin
                out_word_d = in_word;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            ram_we      = 1'b1;
            wr_ptr_d    = ptr_next(wr_ptr_q);
            ram_count_d = ram_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            ram_count_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            drop_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            ram_count_q <= ram_count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[wr_ptr_q] <= in_word;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ctl    = out_word_q[WORD_WIDTH-1 -: CTRL_WIDTH];
    assign out_data   = out_word_q[DATA_WIDTH-1:0];
    assign fill_level = fill_q;
    assign full       = full_w;
    assign drop_pulse = drop_q;

endmodule
`default_nettype wire

// File: doc/egress_port_queue.md
Name: egress_port_queue

Overview:
- Per-output-port buffer placed directly downstream of the 1:4 egress switch; one instance per switch output (ports 0..3).
- The switch drives single-cycle write strobes with no backpressure, so this block absorbs them into a FIFO of {ctl, data} words.
- It presents the words to the port transmitter over a valid/ready handshake.
- Overflow is handled by dropping the incoming word and reporting the drop, never by stalling upstream.

Parameters:
- DATA_WIDTH, 480, width of the packet data word.
- CTRL_WIDTH, 32, width of the control word; bits [1:0] carry the port id.
- ADDR_WIDTH, 4, log2 of queue depth; DEPTH = 2^ADDR_WIDTH entries, including the output register.
- PORT_ID, 0, port number this instance serves; used only by the optional check.

Ports:
- clk  input  1  Single clock for all logic.
- rst  input  1  Asynchronous reset, active-low.
- in_wr  input  1  Write strobe from the switch (its out_wrN).
- in_ctl  input  CTRL_WIDTH  Control word accompanying in_wr.
- in_data  input  DATA_WIDTH  Data word accompanying in_wr.
- out_valid  output  1  Head entry present on out_ctl/out_data.
- out_ready  input  1  Consumer accepts the head this cycle.
- out_ctl  output  CTRL_WIDTH  Head control word (registered).
- out_data  output  DATA_WIDTH  Head data word (registered).
- fill_level  output  ADDR_WIDTH+1  Entries held, 0..DEPTH.
- full  output  1  fill_level == DEPTH.
- drop_pulse  output  1  One-cycle pulse: the previous-cycle write was discarded.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, out_ctl=0, out_data=0, fill_level=0, full=0, drop_pulse=0, read/write pointers=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all entries immediately.
  - The first write after deassertion behaves as a write into an empty queue.
- Storage:
  - Output register plus a RAM of DEPTH-1 entries.
  - fill_level counts both.
  - Pointers wrap modulo DEPTH-1 with no special casing.
- Accept rule:
  - in_wr=1 and full=0: word stored.
  - in_wr=1 and full=1: word discarded and drop_pulse=1 next cycle.
  - A same-cycle pop does NOT make room for a write when full (full is sampled before the pop).
- Fall-through: a word written at edge N into an empty queue appears with out_valid=1 after edge N (visible in cycle N+1). Latency is 1 cycle.
- Pop: when out_valid & out_ready at an edge:
  - The next entry loads into the output register at that same edge, so back-to-back pops sustain 1 word/cycle.
  - If no further entry exists, out_valid falls to 0.
- Simultaneous write + pop with exactly one entry held and RAM empty:
  - The written word goes straight to the output register.
  - fill_level is unchanged (1).
- Handshake stability: while out_valid=1 and out_ready=0, out_ctl/out_data/out_valid hold.
- fill_level:
  - +1 on accepted write.
  - -1 on pop.
  - Unchanged when both occur.
  - Never exceeds DEPTH, never underflows.
- in_wr=0: in_ctl/in_data are ignored.

Optional Feature:
- Macro: EGRESS_PORT_CHECK_EN.
- Defined: an accepted-candidate word with in_ctl[1:0] != PORT_ID[1:0] is discarded (not stored) and pulses drop_pulse, identical to an overflow drop.
- Undefined: in_ctl is stored unexamined; the drop path is overflow only.

Test Plan:
- Reset then a single write (ctl=0x0, data=0xA5) with out_ready=1 -> out_valid=1 one cycle later with data 0xA5; popped next edge; fill_level returns 0.
- ADDR_WIDTH=2, out_ready=0, 6 consecutive writes data 1..6 -> full=1 after 4th; drop_pulse high for the cycles after writes 5 and 6; draining yields 1,2,3,4 in order.
- Steady stream of 20 writes with out_ready=1 -> 20 words out at 1/cycle in order, fill_level <= 1, no drops.
- Full queue, same-cycle write (data 0x77) + pop -> 0x77 dropped, drop_pulse=1, fill_level goes 4->3.
- Reset asserted asynchronously with fill_level=3 -> out_valid=0 and fill_level=0 without a clock edge; a subsequent write of 0x11 emerges first.
- With EGRESS_PORT_CHECK_EN, PORT_ID=2: write ctl[1:0]=1 -> dropped with drop_pulse; write ctl[1:0]=2 -> stored and output.
